// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared widths and FSM state encoding for the instruction memory loader
package instr_loader_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_BYTE_W = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_W;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RB_RD = 3'd3;
  localparam logic [2:0] S_RB_CMP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: control, byte stream and memory write-port bundle of the loader
//   master: loader side (drives byte_ready, mem_*, busy, cpu_hold, done, error)
//   slave:  environment side (drives start, start_addr, word_count, abort, byte_in, byte_valid, mem_q)
interface instr_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BYTE_W = 8
);
  logic start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0] word_count;
  logic abort;
  logic [BYTE_W-1:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_we;
  logic [DATA_WIDTH-1:0] mem_q;
  logic busy;
  logic cpu_hold;
  logic done;
  logic error;
  modport master (
    input start, start_addr, word_count, abort, byte_in, byte_valid, mem_q,
    output byte_ready, mem_data, mem_addr, mem_we, busy, cpu_hold, done, error
  );
  modport slave (
    output start, start_addr, word_count, abort, byte_in, byte_valid, mem_q,
    input byte_ready, mem_data, mem_addr, mem_we, busy, cpu_hold, done, error
  );
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a byte stream little-endian into one word
//   clear: drop partial word; load: insert byte_in at current index
//   word: assembled word; word_full: the byte being loaded completes the word
module byte_word_packer
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic word_full
);
  localparam int BPW = DATA_WIDTH / BYTE_W;
  localparam int IW = $clog2(BPW);
  logic [IW-1:0] idx;
  assign word_full = load && idx == IW'(BPW - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
      word <= '0;
    end else if (load) begin
      word[idx*BYTE_W +: BYTE_W] <= byte_in;
      idx <= word_full ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream loader driving the write port of the instruction memory
//   clk, rst (async, active high); bus: instr_mem_loader_if.master
//   Optional read-back verify enabled by defining INSTR_LOADER_VERIFY_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input logic clk,
  input logic rst,
  instr_mem_loader_if.master bus
);
  logic [2:0] state, nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0] remaining;
  logic [DATA_WIDTH-1:0] word;
  logic full, go, adv, last;
  assign go = state == S_IDLE && bus.start;
  assign last = remaining == (ADDR_WIDTH+1)'(1);
`ifdef INSTR_LOADER_VERIFY_EN
  // address/count advance only after read-back so RB_RD reads the just-written word
  assign adv = state == S_RB_CMP;
`else
  assign adv = state == S_WRITE;
`endif
  byte_word_packer #(.DATA_WIDTH(DATA_WIDTH), .BYTE_W(BYTE_W)) u_packer (
    .clk(clk),
    .rst(rst),
    .clear(go || (bus.abort && state != S_IDLE)),
    .load(bus.byte_valid && bus.byte_ready),
    .byte_in(bus.byte_in),
    .word(word),
    .word_full(full)
  );
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = !bus.start ? S_IDLE : bus.word_count == '0 ? S_DONE : S_COLLECT;
      S_COLLECT: nxt = full ? S_WRITE : S_COLLECT;
`ifdef INSTR_LOADER_VERIFY_EN
      S_WRITE: nxt = S_RB_RD;
      S_RB_RD: nxt = S_RB_CMP;
      S_RB_CMP: nxt = last ? S_DONE : S_COLLECT;
`else
      S_WRITE: nxt = last ? S_DONE : S_COLLECT;
`endif
      default: nxt = S_IDLE;
    endcase
    if (bus.abort && state != S_IDLE) nxt = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr <= '0;
      remaining <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        addr <= bus.start_addr;
        remaining <= bus.word_count;
      end else if (adv) begin
        addr <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
`ifdef INSTR_LOADER_VERIFY_EN
  logic err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (go) err <= 1'b0;
    else if (state == S_RB_CMP && bus.mem_q != word) err <= 1'b1;
  end
  assign bus.error = err;
`else
  assign bus.error = 1'b0;
`endif
  assign bus.byte_ready = state == S_COLLECT;
  assign bus.mem_we = state == S_WRITE;
  assign bus.mem_data = word;
  assign bus.mem_addr = addr;
  assign bus.busy = state != S_IDLE;
  assign bus.cpu_hold = state != S_IDLE;
  assign bus.done = state == S_DONE;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed/randomized bench with a memory model and a word-list reference
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [10:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] mem [0:2047];
  logic [7:0] fixed_bytes[$] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  localparam logic [10:0] CORRUPT_ADDR = 11'h020;
`ifdef INSTR_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  instr_mem_loader_if bus ();
  instr_mem_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // dual-port memory: port B writes (one address corrupted) and reads with 1-cycle latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= (bus.mem_addr == CORRUPT_ADDR) ? ~bus.mem_data : bus.mem_data;
    bus.mem_q <= mem[bus.mem_addr];
  end
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
    end
    if (bus.done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push_byte(input logic [7:0] b, input int gap);
    int k = 0;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    while (!bus.byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("byte_accept_timeout", 1, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask
  task automatic run_load(input string tag, input logic [10:0] saddr, input int wc, input bit fixed, input int gap, input bit mid_start);
    logic [7:0] b[$];
    logic [10:0] ea[$];
    logic [31:0] ed[$];
    bit exp_err = 1'b0;
    int n = 0;
    for (int i = 0; i < 4 * wc; i++) b.push_back(fixed ? fixed_bytes[i] : 8'($urandom));
    for (int i = 0; i < wc; i++) begin
      ea.push_back(11'((int'(saddr) + i) % 2048));
      ed.push_back({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
      if (VERIFY && ea[i] == CORRUPT_ADDR) exp_err = 1'b1;
    end
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    bus.start = 1'b1;
    bus.start_addr = saddr;
    bus.word_count = 12'(wc);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_err_clr"}, bus.error, 0);
    for (int i = 0; i < b.size(); i++) begin
      if (mid_start && i == 5) begin
        bus.start = 1'b1;
        bus.start_addr = ~saddr;
        bus.word_count = 12'd7;
      end
      push_byte(b[i], gap);
      bus.start = 1'b0;
    end
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, bus.done, 1);
    chk({tag, "_busy_at_done"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, {bus.busy, bus.cpu_hold, bus.done}, 0);
    chk({tag, "_nwrites"}, wr_addr.size(), wc);
    for (int i = 0; i < wc && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], ea[i]);
      chk({tag, "_data"}, wr_data[i], ed[i]);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_error"}, bus.error, exp_err);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;
    bus.abort = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done, bus.error}, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_data", bus.mem_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {bus.byte_ready, bus.mem_we, bus.busy, bus.done}, 0);
    run_load("t1_basic", 11'h010, 2, 1'b1, 0, 1'b0);
    run_load("t2_wrap", 11'h7FF, 2, 1'b0, 0, 1'b0);
    run_load("t3_toggle", 11'h010, 2, 1'b1, 1, 1'b0);
    // abort after two bytes of the first word
    wr_addr.delete();
    done_cnt = 0;
    bus.start = 1'b1;
    bus.start_addr = 11'h050;
    bus.word_count = 12'd2;
    @(negedge clk);
    bus.start = 1'b0;
    push_byte(8'($urandom), 0);
    push_byte(8'($urandom), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t4_abort_idle", {bus.busy, bus.byte_ready, bus.mem_we}, 0);
    repeat (3) @(negedge clk);
    chk("t4_abort_nowrite", wr_addr.size(), 0);
    chk("t4_abort_nodone", done_cnt, 0);
    run_load("t4_fresh", 11'h123, 3, 1'b0, 0, 1'b0);
    // zero-length load
    wr_addr.delete();
    bus.start = 1'b1;
    bus.word_count = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_zero_busy_done", {bus.busy, bus.done}, 2'b11);
    @(negedge clk);
    chk("t5_zero_idle", {bus.busy, bus.done}, 0);
    chk("t5_zero_nowrite", wr_addr.size(), 0);
    run_load("t5_midstart", 11'h200, 3, 1'b0, 0, 1'b1);
    run_load("t6_corrupt", 11'h01F, 3, 1'b0, 0, 1'b0);
    run_load("t6_clean", 11'h100, 1, 1'b0, 1, 1'b0);
    for (int r = 0; r < 3; r++) run_load("rand", 11'($urandom), int'($urandom_range(1, 4)), 1'b0, int'($urandom_range(0, 2)), 1'b0);
    // async reset while a write is in progress
    bus.start = 1'b1;
    bus.start_addr = 11'h3C3;
    bus.word_count = 12'd2;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(1, 255)), 0);
    chk("t6_in_write", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done, bus.error}, 0);
    chk("t6_rst_addr", bus.mem_addr, 0);
    chk("t6_rst_data", bus.mem_data, 0);
    @(negedge clk);
    rst = 1'b0;
    run_load("after_rst", 11'h005, 1, 1'b0, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
